// File: rtl/aes_core_arbiter.sv
// Round-robin front end sharing one AES core among NUM_REQ requesters, with a
// run watchdog that resets a silent core and retires the job with an error flag.
//
// state   | meaning
// IDLE    | waiting for a request; grants one requester when the core is out of reset
// RUN     | core_en high, waiting for core_out_valid or watchdog expiry
// RECOVER | core_rst_n held low for two cycles after a watchdog abort
// RESP    | response presented until resp_ready
module aes_core_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   AES_clk,
    input  logic                   AES_rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [128*NUM_REQ-1:0] req_data,
    input  logic [128*NUM_REQ-1:0] req_key,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   core_en,
    output logic [127:0]           core_data,
    output logic [127:0]           core_key,
    output logic                   core_rst_n,
    input  logic                   core_out_valid,
    input  logic [127:0]           core_out,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [127:0]           resp_data,
    output logic                   resp_timeout,
    output logic                   busy
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RECOVER, S_RESP} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant_idx;
    logic           grant_any;
    logic [CW-1:0]  cnt;
    logic           start, done_ok, abort, rec_done;

    // Search starts just after the last winner, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        start     = 1'b0;
        done_ok   = 1'b0;
        abort     = 1'b0;
        rec_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_any && core_rst_n) begin
                    req_ready[grant_idx] = 1'b1;
                    start                = 1'b1;
                    state_nxt            = S_RUN;
                end
            end
            S_RUN: begin
                // A result arriving on the last watchdog cycle still counts.
                if (core_out_valid) begin
                    done_ok   = 1'b1;
                    state_nxt = S_RESP;
                end else if (cnt == '0) begin
                    abort     = 1'b1;
                    state_nxt = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (cnt == '0) begin
                    rec_done  = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign resp_valid = (state == S_RESP);
    assign busy       = (state != S_IDLE);

    // Watchdog is a down-counter: loaded at grant, terminal count is zero.
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            ptr          <= IDW'(NUM_REQ - 1);
            cnt          <= '0;
            core_en      <= 1'b0;
            core_data    <= '0;
            core_key     <= '0;
            core_rst_n   <= 1'b0;
            resp_id      <= '0;
            resp_data    <= '0;
            resp_timeout <= 1'b0;
        end else begin
            if (abort)
                core_rst_n <= 1'b0;
            else if (state != S_RECOVER || rec_done)
                core_rst_n <= 1'b1;

            if (start) begin
                core_data <= req_data[128*grant_idx +: 128];
                core_key  <= req_key[128*grant_idx +: 128];
                resp_id   <= grant_idx;
                ptr       <= grant_idx;
                core_en   <= 1'b1;
                cnt       <= CW'(TIMEOUT - 1);
            end else if (done_ok) begin
                resp_data    <= core_out;
                resp_timeout <= 1'b0;
                core_en      <= 1'b0;
            end else if (abort) begin
                resp_data    <= '0;
                resp_timeout <= 1'b1;
                core_en      <= 1'b0;
                cnt          <= CW'(1);
            end else if ((state == S_RUN || state == S_RECOVER) && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: behavioural core stub with programmable latency,
// vector table of transactions and a response scoreboard.
module tb_aes_core_arbiter;
    localparam int NUM_REQ = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 64;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                   AES_clk = 1'b0;
    logic                   AES_rst = 1'b1;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [128*NUM_REQ-1:0] req_data;
    logic [128*NUM_REQ-1:0] req_key;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   core_en;
    logic [127:0]           core_data;
    logic [127:0]           core_key;
    logic                   core_rst_n;
    logic                   core_out_valid;
    logic [127:0]           core_out;
    logic                   resp_valid;
    logic                   resp_ready = 1'b0;
    logic [IDW-1:0]         resp_id;
    logic [127:0]           resp_data;
    logic                   resp_timeout;
    logic                   busy;

    logic [127:0] pdata [NUM_REQ];
    logic [127:0] pkey  [NUM_REQ];
    int           stub_lat = 0;
    int           stub_cnt = 0;
    logic         stub_valid;
    logic         stray = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NUM_REQ-1:0] mask;
        int                 lat;
        int                 hold;
        int                 exp_id;
        bit                 exp_to;
    } vec_t;

    typedef struct {
        int           id;
        logic [127:0] data;
        bit           to;
    } exp_t;

    exp_t sb [$];
    vec_t tbl [14];

    aes_core_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .AES_clk(AES_clk), .AES_rst(AES_rst),
        .req_valid(req_valid), .req_data(req_data), .req_key(req_key), .req_ready(req_ready),
        .core_en(core_en), .core_data(core_data), .core_key(core_key), .core_rst_n(core_rst_n),
        .core_out_valid(core_out_valid), .core_out(core_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_timeout(resp_timeout), .busy(busy)
    );

    always #5 AES_clk = ~AES_clk;

    // Stand-in for the cipher: the FIPS-197 vector gives its true ciphertext,
    // anything else gets a cheap keyed scramble.
    function automatic logic [127:0] aes_ref(input logic [127:0] d, input logic [127:0] k);
        if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_5a5a_a5a5_a5a5_0f0f_0f0f_f0f0_f0f0;
    endfunction

    always @(posedge AES_clk) begin
        if (!core_en) stub_cnt <= 0;
        else          stub_cnt <= stub_cnt + 1;
    end

    assign stub_valid     = core_en && (stub_lat != 0) && (stub_cnt == stub_lat - 1);
    assign core_out_valid = stub_valid | stray;
    assign core_out       = stub_valid ? aes_ref(core_data, core_key) : ~aes_ref(core_data, core_key);

    always_comb begin
        req_data = '0;
        req_key  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[128*i +: 128] = pdata[i];
            req_key[128*i +: 128]  = pkey[i];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int n);
        int           cyc, en_cnt, rstl_cnt;
        bit           bad_rdy, unstable;
        logic [NUM_REQ-1:0] gnt;
        logic [127:0] h_data;
        logic [IDW-1:0] h_id;
        logic         h_to;
        exp_t         e, a;
        string        tag;
        tag        = $sformatf("txn%0d", n);
        req_valid  = v.mask;
        stub_lat   = v.lat;
        resp_ready = 1'b0;
        #1;
        cyc = 0;
        while (req_ready == '0 && cyc < 200) begin
            @(negedge AES_clk); #1; cyc++;
        end
        gnt = req_ready;
        chk({tag, " grant"}, gnt, NUM_REQ'(1) << v.exp_id);
        e.id   = v.exp_id;
        e.to   = v.exp_to;
        e.data = v.exp_to ? 128'h0 : aes_ref(pdata[v.exp_id], pkey[v.exp_id]);
        sb.push_back(e);

        cyc = 0; en_cnt = 0; rstl_cnt = 0; bad_rdy = 0;
        do begin
            @(negedge AES_clk); #1; cyc++;
            en_cnt   += int'(core_en);
            rstl_cnt += int'(!core_rst_n);
            if (req_ready != '0) bad_rdy = 1;
        end while (!resp_valid && cyc < 300);
        chk({tag, " latency"}, cyc, v.exp_to ? TIMEOUT + 3 : v.lat + 1);
        chk({tag, " core_en cycles"}, en_cnt, v.exp_to ? TIMEOUT : v.lat);
        chk({tag, " core_rst_n low cycles"}, rstl_cnt, v.exp_to ? 2 : 0);

        h_data = resp_data; h_id = resp_id; h_to = resp_timeout;
        unstable = 0;
        stray = 1'b1;
        for (int i = 0; i < v.hold; i++) begin
            @(negedge AES_clk); #1;
            if (resp_data !== h_data || resp_id !== h_id || resp_timeout !== h_to ||
                resp_valid !== 1'b1 || busy !== 1'b1) unstable = 1;
            if (req_ready != '0) bad_rdy = 1;
        end
        stray = 1'b0;
        chk({tag, " resp stable under backpressure"}, unstable, 0);
        chk({tag, " req_ready low while busy"}, bad_rdy, 0);

        resp_ready = 1'b1;
        #1;
        chk({tag, " resp_valid"}, resp_valid, 1);
        if (sb.size() == 0) begin
            chk({tag, " scoreboard not empty"}, 0, 1);
        end else begin
            a = sb.pop_front();
            chk({tag, " resp_id"}, resp_id, a.id);
            chk({tag, " resp_data"}, resp_data, a.data);
            chk({tag, " resp_timeout"}, resp_timeout, a.to);
        end
        @(negedge AES_clk); #1;
        resp_ready = 1'b0;
        chk({tag, " idle after handshake"}, {busy, resp_valid}, 0);
        if (v.hold > 0) chk({tag, " grant one cycle after return"}, req_ready != '0, 1);
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pdata[i] = {$urandom, $urandom, $urandom, $urandom};
            pkey[i]  = {$urandom, $urandom, $urandom, $urandom};
        end
        pdata[1] = FIPS_PT;
        pkey[1]  = FIPS_KEY;

        //          mask     lat hold id timeout
        tbl[0]  = '{4'b0010,  5,  0, 1, 0};
        tbl[1]  = '{4'b1111, 11,  0, 0, 0};
        tbl[2]  = '{4'b1111, 11,  0, 1, 0};
        tbl[3]  = '{4'b1111, 11,  0, 2, 0};
        tbl[4]  = '{4'b1111, 11,  0, 3, 0};
        tbl[5]  = '{4'b1111, 11,  0, 0, 0};
        tbl[6]  = '{4'b0101, 11,  0, 2, 0};
        tbl[7]  = '{4'b0101, 11,  0, 0, 0};
        tbl[8]  = '{4'b0101, 11,  0, 2, 0};
        tbl[9]  = '{4'b1111,  3, 20, 3, 0};
        tbl[10] = '{4'b1111,  0,  0, 0, 1};
        tbl[11] = '{4'b1111,  7,  0, 1, 0};
        tbl[12] = '{4'b1111, 64,  0, 2, 0};
        tbl[13] = '{4'b0001,  1,  2, 0, 0};

        repeat (3) @(negedge AES_clk);
        #1;
        chk("reset outputs", {core_en, core_rst_n, busy, resp_valid, req_ready, resp_timeout, resp_id}, 0);
        chk("reset core_data", core_data, 0);
        chk("reset resp_data", resp_data, 0);

        @(negedge AES_clk);
        req_valid = 4'b0010;
        AES_rst   = 1'b0;
        #1;
        chk("no grant before core_rst_n", {core_rst_n, req_ready}, 0);
        @(negedge AES_clk); #1;
        chk("core_rst_n after release", core_rst_n, 1);

        run_txn(tbl[0], 0);

        // Reset in the middle of a run: everything drops at once, no response.
        req_valid = 4'b1111;
        stub_lat  = 0;
        #1;
        for (int c = 0; c < 50 && req_ready == '0; c++) begin
            @(negedge AES_clk); #1;
        end
        chk("mid-run grant seen", req_ready != '0, 1);
        repeat (5) @(negedge AES_clk);
        #2;
        chk("in RUN before reset", core_en, 1);
        AES_rst = 1'b1;
        #1;
        chk("async reset outputs", {core_en, core_rst_n, busy, resp_valid, req_ready, resp_timeout, resp_id}, 0);
        chk("async reset core_data", core_data, 0);
        chk("async reset core_key", core_key, 0);
        repeat (2) @(negedge AES_clk);
        AES_rst = 1'b0;
        #1;
        chk("core_rst_n low until edge", {core_rst_n, req_ready}, 0);
        @(negedge AES_clk); #1;
        chk("core_rst_n after mid-run reset", core_rst_n, 1);

        for (int n = 1; n < 14; n++) run_txn(tbl[n], n);

        chk("scoreboard drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global timeout: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end
endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Round-robin scheduler that shares one AES_top encryption core among NUM_REQ independent requesters.
- Accepts one plaintext/key pair at a time and drives the core's AES_en, AES_data_in and AES_key_in.
- Captures AES_data_out on AES_data_out_valid and returns it to the owning requester, tagged with that requester's index.
- Watchdog: a core that never responds is reset and the transaction is retired with an error flag.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- IDW, 2: width of requester index; must equal clog2(NUM_REQ).
- TIMEOUT, 64: maximum cycles in RUN before abort (>= 16).

Ports:
- AES_clk  in  1  system clock, rising edge.
- AES_rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_data  in  128*NUM_REQ  plaintext; slot i = [128*i+127:128*i].
- req_key  in  128*NUM_REQ  key; same slot layout.
- req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i]&req_ready[i].
- core_en  out  1  to AES_en.
- core_data  out  128  to AES_data_in.
- core_key  out  128  to AES_key_in.
- core_rst_n  out  1  to AES_rst_n.
- core_out_valid  in  1  from AES_data_out_valid.
- core_out  in  128  from AES_data_out.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  IDW  index of owning requester.
- resp_data  out  128  ciphertext, or 0 on timeout.
- resp_timeout  out  1  response is an abort.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, AES_rst=1): state=IDLE; ptr=NUM_REQ-1; all outputs 0, including core_rst_n.
  - core_rst_n rises on the first AES_clk edge after AES_rst deasserts.
  - Requests are not granted while core_rst_n=0.
- States: IDLE, RUN, RECOVER, RESP.
- IDLE:
  - If any req_valid, grant g = first set bit searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - req_ready = one-hot g (combinational, this cycle only).
  - Registered on that edge: latch req_data[g], req_key[g] into core_data/core_key; resp_id=g; ptr=g; cnt=0; go to RUN.
  - No valid: stay, req_ready=0.
- RUN:
  - core_en=1; core_data/core_key held stable.
  - cnt increments each cycle.
  - core_out_valid=1: register resp_data=core_out, resp_timeout=0; next state RESP; core_en drops in the same edge.
  - cnt==TIMEOUT-1 and no core_out_valid: resp_data=0, resp_timeout=1, core_en=0; next state RECOVER.
  - If valid and timeout coincide, valid wins.
- RECOVER: core_rst_n=0 for exactly 2 cycles, then 1; then RESP.
- RESP:
  - resp_valid=1; resp_data, resp_id and resp_timeout held stable.
  - On resp_valid&resp_ready: go to IDLE; resp_valid falls the next cycle.
  - Earliest next grant is the cycle after return to IDLE (no grant in the handshake cycle).
- core_out_valid outside RUN is ignored.
- req_ready is 0 outside IDLE; requesters must hold req_valid/data/key until accepted.
- Latency:
  - grant edge -> core_en=1 next cycle;
  - core_out_valid cycle -> resp_valid next cycle;
  - total = core latency + 2 cycles.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 transactions.
- core_data/core_key keep their last values when idle and are cleared only by reset.
- Mid-operation AES_rst: immediate return to reset values; any in-flight transaction is lost, with no response.

Test Plan:
- Single request, real AES_top: req 1 with key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff -> one req_ready[1] pulse; resp_valid with resp_id=1, resp_data=69c4e0d86a7b0430d8cdb78070b4c55a, resp_timeout=0.
- Round-robin: req_valid=4'b1111 held, resp_ready=1, stub core with 11-cycle latency -> grant order 0,1,2,3,0.
  - Repeat after one transaction with only 0 and 2 valid -> order 2,0,2.
- Backpressure: resp_ready=0 for 20 cycles after resp_valid -> resp fields stable, req_ready=0 throughout, busy=1; resp_ready=1 -> IDLE, next grant 1 cycle later.
- Timeout: stub never asserts valid, TIMEOUT=64 -> core_en high exactly 64 cycles; core_rst_n low 2 cycles; resp_timeout=1, resp_data=0; the following request completes normally.
- Valid/timeout collision: stub asserts valid at cnt=TIMEOUT-1 -> normal response, core_rst_n never pulses.
- Reset mid-RUN: assert AES_rst 5 cycles into RUN -> all outputs 0 asynchronously; after release core_rst_n=1 one edge later; first grant goes to requester 0 if req_valid=4'b1111.
